moore_stepper_tx: RTL and testbench

Transmit side of the serial step interface: drives the single-bit `x` line of the 2-bit up-counting Moore machine so that its state lands on a requested target value. The block keeps a mirror of the receiver's state, computes the modulo-2^W step distance, and emits that many one-cycle `x` pulses with a programmable idle gap. It sits between control logic issuing `req_target` commands and the downstream Moore machine's `x` input.

---
 rtl/moore_stepper_tx_pkg.sv | 21 ++
 rtl/moore_stepper_tx.sv | 93 +++++++++
 tb/tb_moore_stepper_tx.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/moore_stepper_tx_pkg.sv
// Shared definitions for the serial step transmitter and its receiver models:
// FSM state encoding and modulo subtraction at an arbitrary state width.
package moore_stepper_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } tx_state_e;

    // (a - b) mod 2^width, unsigned, for widths up to 32 bits.
    function automatic int unsigned wrap_sub(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned width);
        int unsigned mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/moore_stepper_tx.sv
// Drives the x line of an up-counting Moore receiver so that its state reaches
// a requested target, keeping a local mirror of the receiver state.
module moore_stepper_tx
    import moore_stepper_tx_pkg::*;
#(
    parameter int STATE_W    = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               req_valid,
    input  logic [STATE_W-1:0] req_target,
    output logic               req_ready,
    output logic               x,
    output logic [STATE_W-1:0] mirror_state,
    output logic               busy,
    output logic               done
);

    localparam int GAP_W = (GAP_CYCLES > 0) ? (($clog2(GAP_CYCLES + 1) > 0) ? $clog2(GAP_CYCLES + 1) : 1) : 1;
    // The gap counter counts down to zero, so GAP_CYCLES idle cycles need a load of GAP_CYCLES-1.
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    tx_state_e          state_q,     state_d;
    logic [STATE_W-1:0] mirror_q,    mirror_d;
    logic [STATE_W-1:0] remaining_q, remaining_d;
    logic [GAP_W-1:0]   gap_cnt_q,   gap_cnt_d;
    logic [STATE_W-1:0] distance;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            mirror_q    <= '0;
            remaining_q <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mirror_q    <= mirror_d;
            remaining_q <= remaining_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mirror_d    = mirror_q;
        remaining_d = remaining_q;
        gap_cnt_d   = gap_cnt_q;
        distance    = STATE_W'(wrap_sub(32'(req_target), 32'(mirror_q), unsigned'(STATE_W)));

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    remaining_d = distance;
                    state_d     = (distance == '0) ? ST_DONE : ST_PULSE;
                end
            end
            ST_PULSE: begin
                mirror_d    = mirror_q + STATE_W'(1);
                remaining_d = remaining_q - STATE_W'(1);
                // The last pulse goes straight to DONE; no trailing gap.
                if (remaining_q == STATE_W'(1)) begin
                    state_d = ST_DONE;
                end else if (GAP_CYCLES > 0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    state_d = ST_PULSE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_PULSE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign x            = (state_q == ST_PULSE);
    assign done         = (state_q == ST_DONE);
    assign busy         = (state_q != ST_IDLE);
    assign req_ready    = (state_q == ST_IDLE);
    assign mirror_state = mirror_q;

endmodule

// File: tb/tb_moore_stepper_tx.sv
// Scoreboard bench for moore_stepper_tx: three instances with gaps 0, 1 and 3
// driving behavioural receivers, checked against timing derived from step counts.
module tb_moore_stepper_tx;

    localparam int W    = 2;
    localparam int M    = 4;
    localparam int NDUT = 3;

    logic            clk = 1'b0;
    logic            n_rst;
    logic [NDUT-1:0] req_valid;
    logic [W-1:0]    req_target [NDUT];
    logic [NDUT-1:0] req_ready;
    logic [NDUT-1:0] x;
    logic [NDUT-1:0] busy;
    logic [NDUT-1:0] done;
    logic [W-1:0]    mirror [NDUT];
    logic [W-1:0]    rx [NDUT];

    typedef struct {
        int dut;
        bit is_done;
        int cyc;
        int mirror;
    } ev_t;

    ev_t sb[$];
    int  model_mirror [NDUT];
    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;

    moore_stepper_tx #(.STATE_W(W), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .n_rst(n_rst), .req_valid(req_valid[0]), .req_target(req_target[0]),
        .req_ready(req_ready[0]), .x(x[0]), .mirror_state(mirror[0]), .busy(busy[0]), .done(done[0]));
    moore_stepper_tx #(.STATE_W(W), .GAP_CYCLES(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .req_valid(req_valid[1]), .req_target(req_target[1]),
        .req_ready(req_ready[1]), .x(x[1]), .mirror_state(mirror[1]), .busy(busy[1]), .done(done[1]));
    moore_stepper_tx #(.STATE_W(W), .GAP_CYCLES(3)) dut2 (
        .clk(clk), .n_rst(n_rst), .req_valid(req_valid[2]), .req_target(req_target[2]),
        .req_ready(req_ready[2]), .x(x[2]), .mirror_state(mirror[2]), .busy(busy[2]), .done(done[2]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural receivers: each advances by one on every clock where x is high.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int d = 0; d < NDUT; d++) rx[d] <= '0;
        end else begin
            for (int d = 0; d < NDUT; d++) if (x[d]) rx[d] <= rx[d] + 2'd1;
        end
    end

    function automatic int gap_of(input int d);
        case (d)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Waits for the instance to be idle, issues one command and queues the predicted events.
    // With hold set, req_valid stays high afterwards and req_target is scrambled while busy.
    task automatic applyStimulus(input int d, input int target, input bit hold);
        int  n, g, base, waitc;
        ev_t e;
        waitc = 0;
        while (1) begin
            @(negedge clk);
            if (req_ready[d]) break;
            if (req_valid[d]) req_target[d] = W'($urandom_range(0, M - 1));
            waitc++;
            if (waitc > 500) begin
                checkOutput($sformatf("dut%0d ready timeout", d), int'(req_ready[d]), 1);
                return;
            end
        end
        base = cyc;
        g    = gap_of(d);
        n    = (((target - model_mirror[d]) % M) + M) % M;
        req_target[d] = W'(target);
        req_valid[d]  = 1'b1;
        for (int k = 0; k < n; k++) begin
            e.dut = d; e.is_done = 1'b0; e.cyc = base + 1 + k * (g + 1);
            e.mirror = (model_mirror[d] + k) % M;
            sb.push_back(e);
        end
        e.dut = d; e.is_done = 1'b1;
        e.cyc = (n == 0) ? base + 1 : base + (n - 1) * (g + 1) + 2;
        e.mirror = target % M;
        sb.push_back(e);
        model_mirror[d] = target % M;
        @(posedge clk);
        #1;
        checkOutput($sformatf("dut%0d busy after accept", d), int'(busy[d]), 1);
        checkOutput($sformatf("dut%0d ready after accept", d), int'(req_ready[d]), 0);
        if (!hold) req_valid[d] = 1'b0;
    endtask

    // Monitor: every x or done pulse must match the oldest pending event of that instance.
    always @(negedge clk) begin
        if (n_rst) begin
            for (int d = 0; d < NDUT; d++) begin
                int  idx;
                ev_t e;
                idx = -1;
                for (int i = 0; i < sb.size(); i++) begin
                    if (sb[i].dut == d) begin
                        idx = i;
                        break;
                    end
                end
                if (idx >= 0 && sb[idx].cyc < cyc) begin
                    checkOutput($sformatf("dut%0d missed event cycle", d), cyc, sb[idx].cyc);
                    sb.delete(idx);
                end else if (x[d] || done[d]) begin
                    if (idx < 0) begin
                        checkOutput($sformatf("dut%0d unexpected x/done", d), int'({x[d], done[d]}), 0);
                    end else begin
                        e = sb[idx];
                        sb.delete(idx);
                        checkOutput($sformatf("dut%0d done level", d), int'(done[d]), int'(e.is_done));
                        checkOutput($sformatf("dut%0d x level", d), int'(x[d]), int'(!e.is_done));
                        checkOutput($sformatf("dut%0d event cycle", d), cyc, e.cyc);
                        checkOutput($sformatf("dut%0d mirror", d), int'(mirror[d]), e.mirror);
                        checkOutput($sformatf("dut%0d busy", d), int'(busy[d]), 1);
                        if (e.is_done)
                            checkOutput($sformatf("dut%0d receiver state", d), int'(rx[d]), e.mirror);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic drain();
        int waitc;
        waitc = 0;
        while (sb.size() != 0 && waitc < 2000) begin
            @(negedge clk);
            waitc++;
        end
        checkOutput("scoreboard drained", sb.size(), 0);
    endtask

    initial begin
        int m0;
        n_rst     = 1'b0;
        req_valid = '0;
        for (int d = 0; d < NDUT; d++) begin
            req_target[d]   = '0;
            model_mirror[d] = 0;
        end
        #12;
        for (int d = 0; d < NDUT; d++) begin
            checkOutput($sformatf("dut%0d reset x", d), int'(x[d]), 0);
            checkOutput($sformatf("dut%0d reset done", d), int'(done[d]), 0);
            checkOutput($sformatf("dut%0d reset mirror", d), int'(mirror[d]), 0);
            checkOutput($sformatf("dut%0d reset busy", d), int'(busy[d]), 0);
            checkOutput($sformatf("dut%0d reset ready", d), int'(req_ready[d]), 1);
        end
        @(negedge clk);
        n_rst = 1'b1;

        applyStimulus(1, 2, 1'b0);
        applyStimulus(1, 1, 1'b0);
        applyStimulus(1, 1, 1'b0);
        applyStimulus(0, 3, 1'b0);
        applyStimulus(2, 2, 1'b1);
        applyStimulus(2, 1, 1'b0);
        drain();

        repeat (30) begin
            applyStimulus(int'($urandom_range(0, NDUT - 1)), int'($urandom_range(0, M - 1)), 1'b0);
        end
        drain();

        // Abort a three-step command in the gap after its first pulse.
        m0 = model_mirror[1];
        applyStimulus(1, (m0 + 3) % M, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        checkOutput("abort x", int'(x[1]), 0);
        checkOutput("abort done", int'(done[1]), 0);
        checkOutput("abort mirror", int'(mirror[1]), 0);
        checkOutput("abort busy", int'(busy[1]), 0);
        checkOutput("abort ready", int'(req_ready[1]), 1);
        sb.delete();
        for (int d = 0; d < NDUT; d++) model_mirror[d] = 0;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("abort receiver idle", int'(rx[1]), 0);
        checkOutput("abort ready after release", int'(req_ready[1]), 1);

        applyStimulus(1, 3, 1'b0);
        applyStimulus(0, 2, 1'b0);
        applyStimulus(2, 1, 1'b0);
        drain();
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
